// File: rtl/mont_precomp.sv
// Montgomery precompute: R mod n, R^2 mod n and -n^-1 mod 2^R_WIDTH for an odd modulus n.
// Build option: define MONT_PRECOMP_R2_EN to also produce r2 (otherwise r2 is tied to 0).
module mont_precomp #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned S       = 2,
    parameter int unsigned R_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [S-1:0][WIDTH-1:0]   n,
    output logic [S-1:0][WIDTH-1:0]   mont_one,
    output logic [S-1:0][WIDTH-1:0]   r2,
    output logic [R_WIDTH-1:0]        n_prime,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    localparam int unsigned NW = WIDTH * S;
`ifdef MONT_PRECOMP_R2_EN
    localparam int unsigned NDBL = 2 * NW;
`else
    localparam int unsigned NDBL = NW;
`endif
    localparam int unsigned IW = $clog2(R_WIDTH);
    localparam int unsigned CW = $clog2(NDBL + 1);

    // StDone holds the one-cycle done pulse and otherwise behaves exactly like StIdle.
    typedef enum logic [2:0] {StIdle, StCheck, StNprime, StDouble, StDone} state_e;

    state_e             state_q;
    logic [NW-1:0]      n_q;
    logic [R_WIDTH-1:0] y_q;
    logic [NW-1:0]      x_q;
    logic [IW-1:0]      i_q;
    logic [CW-1:0]      d_q;
    logic [NW-1:0]      mont_one_q;
    logic [R_WIDTH-1:0] n_prime_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;

    logic [R_WIDTH-1:0] prod;
    logic [R_WIDTH-1:0] y_next;
    logic [NW:0]        x_dbl;
    logic [NW-1:0]      x_next;
    logic [CW-1:0]      d_inc;

    always_comb begin
        prod   = n_q[R_WIDTH-1:0] * y_q;
        y_next = y_q;
        if (prod[i_q]) begin
            y_next[i_q] = 1'b1;
        end
        // x < n on entry, so 2x < 2n and a single subtract brings it back below n.
        x_dbl  = {x_q, 1'b0};
        x_next = (x_dbl >= {1'b0, n_q}) ? NW'(x_dbl - {1'b0, n_q}) : x_dbl[NW-1:0];
        d_inc  = d_q + CW'(1);
    end

`ifdef MONT_PRECOMP_R2_EN
    logic [NW-1:0] r2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r2_q <= '0;
        end else if (state_q == StCheck && !n_q[0]) begin
            r2_q <= '0;
        end else if (state_q == StDouble && d_inc == CW'(NDBL)) begin
            r2_q <= x_next;
        end
    end

    assign r2 = r2_q;
`else
    assign r2 = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            n_q        <= '0;
            y_q        <= '0;
            x_q        <= '0;
            i_q        <= '0;
            d_q        <= '0;
            mont_one_q <= '0;
            n_prime_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        n_q     <= n;
                        busy_q  <= 1'b1;
                        err_q   <= 1'b0;
                        state_q <= StCheck;
                    end
                end
                StCheck: begin
                    if (!n_q[0]) begin
                        mont_one_q <= '0;
                        n_prime_q  <= '0;
                        err_q      <= 1'b1;
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= StDone;
                    end else begin
                        y_q     <= R_WIDTH'(1);
                        i_q     <= IW'(1);
                        x_q     <= (n_q == NW'(1)) ? '0 : NW'(1);
                        state_q <= StNprime;
                    end
                end
                StNprime: begin
                    y_q <= y_next;
                    if (i_q == IW'(R_WIDTH - 1)) begin
                        n_prime_q <= R_WIDTH'(0) - y_next;
                        i_q       <= '0;
                        d_q       <= '0;
                        state_q   <= StDouble;
                    end else begin
                        i_q <= i_q + IW'(1);
                    end
                end
                StDouble: begin
                    x_q <= x_next;
                    d_q <= d_inc;
                    if (d_inc == CW'(NW)) begin
                        mont_one_q <= x_next;
                    end
                    if (d_inc == CW'(NDBL)) begin
                        d_q     <= '0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StDone;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign mont_one = mont_one_q;
    assign n_prime  = n_prime_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_mont_precomp.sv
// Randomized self-checking bench for mont_precomp against an arithmetic reference model.
// Honours MONT_PRECOMP_R2_EN for the expected r2 and latency.
module tb_mont_precomp;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned S       = 2;
    localparam int unsigned R_WIDTH = 8;
`ifdef MONT_PRECOMP_R2_EN
    localparam int unsigned LAT   = R_WIDTH + 2 * WIDTH * S;
    localparam bit          R2_EN = 1'b1;
`else
    localparam int unsigned LAT   = R_WIDTH + WIDTH * S;
    localparam bit          R2_EN = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic [S-1:0][WIDTH-1:0] n;
    logic [S-1:0][WIDTH-1:0] mont_one;
    logic [S-1:0][WIDTH-1:0] r2;
    logic [R_WIDTH-1:0]      n_prime;
    logic                    busy;
    logic                    done;
    logic                    err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mont_precomp #(
        .WIDTH   (WIDTH),
        .S       (S),
        .R_WIDTH (R_WIDTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .n        (n),
        .mont_one (mont_one),
        .r2       (r2),
        .n_prime  (n_prime),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // mode: 0 plain, 1 extra start pulse mid-run, 2 reset at cycle 20, 3 start on the first
    // edge without re-aligning to a falling edge (used right after reset release)
    task automatic run(input int unsigned nv, input int mode);
        longint unsigned em;
        longint unsigned er;
        int unsigned     enp;
        int unsigned     elat;
        bit              even;
        int              cycles;
        even = (nv % 2 == 0);
        em   = even ? 0 : (64'd1 << (WIDTH * S)) % nv;
        er   = (even || !R2_EN) ? 0 : (64'd1 << (2 * WIDTH * S)) % nv;
        elat = even ? 1 : LAT;
        enp  = 0;
        if (!even) begin
            for (int v = 0; v < (1 << R_WIDTH); v++) begin
                if (((nv * v) % (1 << R_WIDTH)) == (1 << R_WIDTH) - 1) enp = v;
            end
        end
        if (mode != 3) @(negedge clk);
        n     = nv[15:0];
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", busy, 1);
        cycles = 0;
        while (!done && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
            if (mode == 1 && cycles == 10) begin
                n     = 16'h0010;
                start = 1'b1;
            end
            if (mode == 1 && cycles == 11) start = 1'b0;
            if (mode == 2 && cycles == 20) begin
                rst = 1'b1;
                #1;
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_err", err, 0);
                check("rst_mont_one", mont_one, 0);
                check("rst_r2", r2, 0);
                check("rst_n_prime", n_prime, 0);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
        end
        check("latency", cycles, elat);
        check("mont_one", mont_one, em);
        check("r2", r2, er);
        check("n_prime", n_prime, enp);
        check("err", err, even);
        check("busy_at_done", busy, 0);
        @(posedge clk);
        #1;
        check("done_single_pulse", done, 0);
        check("mont_one_hold", mont_one, em);
        check("err_hold", err, even);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        n     = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_err", err, 0);
        check("reset_mont_one", mont_one, 0);
        check("reset_r2", r2, 0);
        check("reset_n_prime", n_prime, 0);
        @(negedge clk);
        rst = 1'b0;

        run(16'h00F1, 0);
        run(16'hFFFF, 0);
        run(16'h0010, 0);
        run(16'h0001, 0);
        run(16'h00F1, 1);
        run(16'h00F1, 2);
        run(16'hFFFF, 3);
        for (int k = 0; k < 24; k++) begin
            int unsigned nv;
            nv = $urandom_range(0, 65535);
            if (k % 4 != 0) nv = nv | 1;
            run(nv, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
